// File: rtl/score4_pkg.sv
// Shared types and constants for the Connect-N game engine and its helpers.
package score4_pkg;

    // Contents of one board cell
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P_A   = 2'b01,
        P_B   = 2'b10
    } cell_t;

    // Engine sequencing states
    typedef enum logic [2:0] {
        IDLE,
        DROP,
        CHECK,
        NEXT,
        OVER
    } fsm_t;

    // Scan directions, visited in this order while checking a move
    localparam logic [1:0] DIR_H  = 2'd0;  // step (+1,  0)
    localparam logic [1:0] DIR_V  = 2'd1;  // step ( 0, +1)
    localparam logic [1:0] DIR_D1 = 2'd2;  // step (+1, +1), rising diagonal
    localparam logic [1:0] DIR_D2 = 2'd3;  // step (+1, -1), falling diagonal

    // Column step for a direction
    function automatic int dir_dc(input logic [1:0] dir);
        int dc;
        dc = (dir == DIR_V) ? 0 : 1;
        return dc;
    endfunction

    // Row step for a direction
    function automatic int dir_dr(input logic [1:0] dir);
        int dr;
        case (dir)
            DIR_H:   dr = 0;
            DIR_D2:  dr = -1;
            default: dr = 1;
        endcase
        return dr;
    endfunction

endpackage

// File: rtl/connect_n_line_counter.sv
// Combinational run-length counter: length of the same-colour run through
// one cell along one direction, looking both ways and stopping at the edges.
module connect_n_line_counter
    import score4_pkg::*;
#(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    localparam int CW   = $clog2(COLS),
    localparam int RW   = $clog2(ROWS),
    localparam int MAXD = (COLS > ROWS) ? COLS : ROWS,
    localparam int NW   = $clog2(MAXD) + 1
) (
    input  logic [COLS-1:0][ROWS-1:0][1:0] board,
    input  logic [CW-1:0]                  col,
    input  logic [RW-1:0]                  row,
    input  logic [1:0]                     dir,
    input  cell_t                          colour,
    output logic [NW-1:0]                  run_len
);

    // Walk outward on each side of the cell until a different cell or the edge
    always_comb begin
        int dc;
        int dr;
        int cc;
        int rr;
        logic going;
        logic [NW-1:0] cnt;
        cnt = NW'(1);
        dc  = dir_dc(dir);
        dr  = dir_dr(dir);
        for (int s = 0; s < 2; s++) begin
            going = 1'b1;
            cc    = int'(col);
            rr    = int'(row);
            for (int k = 1; k < MAXD; k++) begin
                cc = (s == 0) ? cc + dc : cc - dc;
                rr = (s == 0) ? rr + dr : rr - dr;
                if (going && cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) begin
                    if (board[cc[CW-1:0]][rr[RW-1:0]] == colour) begin
                        cnt = cnt + 1'b1;
                    end else begin
                        going = 1'b0;
                    end
                end else begin
                    going = 1'b0;
                end
            end
        end
        run_len = cnt;
    end

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N game-state engine: owns board, cursor, turn and result, driven
// by debounced cursor/drop buttons.
module connect_n_engine
    import score4_pkg::*;
#(
    parameter int COLS        = 7,
    parameter int ROWS        = 6,
    parameter int WIN_LEN     = 4,
    parameter int CURSOR_WRAP = 1,
    parameter int FIRST_B     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          left,
    input  logic                          right,
    input  logic                          put,
    output logic [COLS-1:0][ROWS-1:0][1:0] panel,
    output logic [COLS-1:0]               play,
    output logic                          turn,
    output logic                          player,
    output logic                          invalid_move,
    output logic                          win_a,
    output logic                          win_b,
    output logic                          full_panel,
    output logic                          busy
);

    localparam int CW        = $clog2(COLS);
    localparam int RW        = $clog2(ROWS);
    localparam int MAXD      = (COLS > ROWS) ? COLS : ROWS;
    localparam int NW        = $clog2(MAXD) + 1;
    localparam int START_COL = (COLS - 1) / 2;

    logic          left_q;
    logic          right_q;
    logic          put_q;
    logic          ev_left;
    logic          ev_right;
    logic          ev_put;
    fsm_t          state;
    logic [CW-1:0] cur_col;
    logic [CW-1:0] col_dec;
    logic [CW-1:0] col_inc;
    logic [CW-1:0] drop_col;
    logic [RW-1:0] drop_row;
    logic [RW-1:0] free_row;
    logic [1:0]    dir_idx;
    logic          win_seen;
    logic          col_full;
    logic          board_full;
    logic          hit;
    logic [NW-1:0] run_len;
    cell_t         cur_colour;

    assign ev_left    = left & ~left_q;
    assign ev_right   = right & ~right_q;
    assign ev_put     = put & ~put_q;
    assign cur_colour = turn ? P_B : P_A;
    assign player     = turn;
    assign col_full   = (panel[cur_col][RW'(ROWS-1)] != EMPTY);
    assign hit        = (run_len >= NW'(WIN_LEN));

    // Neighbouring cursor columns, wrapping or saturating at the edges
    always_comb begin
        col_dec = cur_col - 1'b1;
        col_inc = cur_col + 1'b1;
        if (cur_col == '0) begin
            col_dec = (CURSOR_WRAP != 0) ? CW'(COLS-1) : '0;
        end
        if (cur_col == CW'(COLS-1)) begin
            col_inc = (CURSOR_WRAP != 0) ? '0 : CW'(COLS-1);
        end
    end

    // One-hot view of the cursor column
    always_comb begin
        play          = '0;
        play[cur_col] = 1'b1;
    end

    // Lowest empty row in the column being dropped into
    always_comb begin
        free_row = '0;
        for (int r = ROWS-1; r >= 0; r--) begin
            if (panel[drop_col][RW'(r)] == EMPTY) begin
                free_row = RW'(r);
            end
        end
    end

    // Board is full once every top-row cell is occupied
    always_comb begin
        board_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (panel[CW'(c)][RW'(ROWS-1)] == EMPTY) begin
                board_full = 1'b0;
            end
        end
    end

    connect_n_line_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_line_counter (
        .board   (panel),
        .col     (drop_col),
        .row     (drop_row),
        .dir     (dir_idx),
        .colour  (cur_colour),
        .run_len (run_len)
    );

    // Button edge history, cursor, board writes, move evaluation and result flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            put_q        <= 1'b0;
            state        <= IDLE;
            cur_col      <= CW'(START_COL);
            drop_col     <= '0;
            drop_row     <= '0;
            dir_idx      <= '0;
            win_seen     <= 1'b0;
            panel        <= '0;
            turn         <= (FIRST_B != 0);
            invalid_move <= 1'b0;
            win_a        <= 1'b0;
            win_b        <= 1'b0;
            full_panel   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            left_q  <= left;
            right_q <= right;
            put_q   <= put;
            case (state)
                IDLE: begin
                    if (ev_put) begin
                        if (col_full) begin
                            invalid_move <= 1'b1;
                        end else begin
                            invalid_move <= 1'b0;
                            drop_col     <= cur_col;
                            busy         <= 1'b1;
                            state        <= DROP;
                        end
                    end else if (ev_left ^ ev_right) begin
                        invalid_move <= 1'b0;
                        cur_col      <= ev_left ? col_dec : col_inc;
                    end
                end
                DROP: begin
                    panel[drop_col][free_row] <= cur_colour;
                    drop_row                  <= free_row;
                    dir_idx                   <= DIR_H;
                    win_seen                  <= 1'b0;
                    state                     <= CHECK;
                end
                CHECK: begin
                    win_seen <= win_seen | hit;
                    dir_idx  <= dir_idx + 2'd1;
                    if (dir_idx == DIR_D2) begin
                        if (win_seen | hit | board_full) begin
                            state <= OVER;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    turn  <= ~turn;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                OVER: begin
                    if (busy) begin
                        busy <= 1'b0;
                        if (win_seen) begin
                            if (turn) begin
                                win_b <= 1'b1;
                            end else begin
                                win_a <= 1'b1;
                            end
                        end else begin
                            full_panel <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_connect_n_engine.sv
// Directed self-checking bench for connect_n_engine across several board shapes.
module tb_connect_n_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] left_i  = '0;
    logic [4:0] right_i = '0;
    logic [4:0] put_i   = '0;

    logic [4:0] turn_o, player_o, inval_o, win_a_o, win_b_o, full_o, busy_o;

    logic [6:0][5:0][1:0] panel0, panel1;
    logic [7:0][6:0][1:0] panel2;
    logic [2:0][2:0][1:0] panel3;
    logic [2:0][1:0][1:0] panel4;
    logic [6:0] play0, play1;
    logic [7:0] play2;
    logic [2:0] play3, play4;

    logic [6:0][5:0][1:0] exp_panel;

    int checks   = 0;
    int failures = 0;
    int cur_col [5];

    always #5 clk = ~clk;

    connect_n_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4), .CURSOR_WRAP(1), .FIRST_B(0)) u0 (
        .clk(clk), .rst(rst), .left(left_i[0]), .right(right_i[0]), .put(put_i[0]),
        .panel(panel0), .play(play0), .turn(turn_o[0]), .player(player_o[0]),
        .invalid_move(inval_o[0]), .win_a(win_a_o[0]), .win_b(win_b_o[0]),
        .full_panel(full_o[0]), .busy(busy_o[0]));

    connect_n_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4), .CURSOR_WRAP(0), .FIRST_B(0)) u1 (
        .clk(clk), .rst(rst), .left(left_i[1]), .right(right_i[1]), .put(put_i[1]),
        .panel(panel1), .play(play1), .turn(turn_o[1]), .player(player_o[1]),
        .invalid_move(inval_o[1]), .win_a(win_a_o[1]), .win_b(win_b_o[1]),
        .full_panel(full_o[1]), .busy(busy_o[1]));

    connect_n_engine #(.COLS(8), .ROWS(7), .WIN_LEN(5), .CURSOR_WRAP(1), .FIRST_B(0)) u2 (
        .clk(clk), .rst(rst), .left(left_i[2]), .right(right_i[2]), .put(put_i[2]),
        .panel(panel2), .play(play2), .turn(turn_o[2]), .player(player_o[2]),
        .invalid_move(inval_o[2]), .win_a(win_a_o[2]), .win_b(win_b_o[2]),
        .full_panel(full_o[2]), .busy(busy_o[2]));

    connect_n_engine #(.COLS(3), .ROWS(3), .WIN_LEN(3), .CURSOR_WRAP(1), .FIRST_B(0)) u3 (
        .clk(clk), .rst(rst), .left(left_i[3]), .right(right_i[3]), .put(put_i[3]),
        .panel(panel3), .play(play3), .turn(turn_o[3]), .player(player_o[3]),
        .invalid_move(inval_o[3]), .win_a(win_a_o[3]), .win_b(win_b_o[3]),
        .full_panel(full_o[3]), .busy(busy_o[3]));

    connect_n_engine #(.COLS(3), .ROWS(2), .WIN_LEN(3), .CURSOR_WRAP(1), .FIRST_B(0)) u4 (
        .clk(clk), .rst(rst), .left(left_i[4]), .right(right_i[4]), .put(put_i[4]),
        .panel(panel4), .play(play4), .turn(turn_o[4]), .player(player_o[4]),
        .invalid_move(inval_o[4]), .win_a(win_a_o[4]), .win_b(win_b_o[4]),
        .full_panel(full_o[4]), .busy(busy_o[4]));

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Pulse one button (0 left, 1 right, 2 put, 3 left+right) for one cycle, then release
    task automatic applyStimulus(input int inst, input int kind);
        @(negedge clk);
        case (kind)
            0: left_i[inst] = 1'b1;
            1: right_i[inst] = 1'b1;
            2: put_i[inst] = 1'b1;
            default: begin
                left_i[inst]  = 1'b1;
                right_i[inst] = 1'b1;
            end
        endcase
        @(negedge clk);
        left_i[inst]  = 1'b0;
        right_i[inst] = 1'b0;
        put_i[inst]   = 1'b0;
        @(negedge clk);
    endtask

    task automatic goto_col(input int inst, input int target);
        while (cur_col[inst] < target) begin
            applyStimulus(inst, 1);
            cur_col[inst]++;
        end
        while (cur_col[inst] > target) begin
            applyStimulus(inst, 0);
            cur_col[inst]--;
        end
    endtask

    // Move to a column, drop, and wait until the move has been fully evaluated
    task automatic drop_piece(input int inst, input int col);
        goto_col(inst, col);
        applyStimulus(inst, 2);
        repeat (5) @(negedge clk);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst     = 1'b0;
        left_i  = '0;
        right_i = '0;
        put_i   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cur_col = '{3, 3, 3, 1, 1};
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        cur_col = '{3, 3, 3, 1, 1};
        reset_all();

        // Reset state
        checkOutput("rst_panel", panel0, 0);
        checkOutput("rst_play", play0, 7'b0001000);
        checkOutput("rst_turn", turn_o[0], 0);
        checkOutput("rst_flags", {inval_o[0], win_a_o[0], win_b_o[0], full_o[0], busy_o[0]}, 0);
        checkOutput("rst_play_3x3", play3, 3'b010);

        // Cursor wrap, simultaneous buttons, saturation
        repeat (4) applyStimulus(0, 0);
        cur_col[0] = 6;
        checkOutput("wrap_left", play0, 7'b1000000);
        applyStimulus(0, 3);
        checkOutput("left_right_same", play0, 7'b1000000);
        repeat (5) applyStimulus(1, 0);
        cur_col[1] = 0;
        checkOutput("saturate_left", play1, 7'b0000001);

        // Fill column 3, then overfill it
        for (int i = 0; i < 6; i++) drop_piece(0, 3);
        exp_panel    = '0;
        exp_panel[3] = 12'h999;
        checkOutput("col_fill_panel", panel0, exp_panel);
        checkOutput("col_fill_turn", turn_o[0], 0);
        applyStimulus(0, 2);
        checkOutput("invalid_set", inval_o[0], 1);
        checkOutput("invalid_turn", turn_o[0], 0);
        checkOutput("invalid_panel", panel0, exp_panel);
        applyStimulus(0, 1);
        cur_col[0] = 4;
        checkOutput("invalid_clear", inval_o[0], 0);
        checkOutput("invalid_play", play0, 7'b0010000);

        // Vertical win for A, with result latency
        reset_all();
        for (int i = 0; i < 3; i++) begin
            drop_piece(0, 0);
            drop_piece(0, 1);
        end
        goto_col(0, 0);
        applyStimulus(0, 2);
        checkOutput("win_busy_mid", busy_o[0], 1);
        repeat (4) @(negedge clk);
        checkOutput("win_a_early", win_a_o[0], 0);
        checkOutput("win_busy_late", busy_o[0], 1);
        @(negedge clk);
        checkOutput("win_a", win_a_o[0], 1);
        checkOutput("win_busy_done", busy_o[0], 0);
        checkOutput("win_b_clear", win_b_o[0], 0);
        exp_panel    = '0;
        exp_panel[0] = 12'h055;
        exp_panel[1] = 12'h02A;
        checkOutput("win_panel", panel0, exp_panel);
        applyStimulus(0, 2);
        applyStimulus(0, 0);
        repeat (8) @(negedge clk);
        checkOutput("over_panel", panel0, exp_panel);
        checkOutput("over_play", play0, 7'b0000001);
        checkOutput("over_win_a", win_a_o[0], 1);

        // Rising-diagonal win for B on an 8x7 board needing 5
        reset_all();
        drop_piece(2, 1); drop_piece(2, 0); drop_piece(2, 2); drop_piece(2, 1);
        drop_piece(2, 4); drop_piece(2, 2); drop_piece(2, 4); drop_piece(2, 2);
        drop_piece(2, 4); drop_piece(2, 3); drop_piece(2, 3); drop_piece(2, 4);
        drop_piece(2, 3); drop_piece(2, 3); drop_piece(2, 7);
        checkOutput("diag_no_win_yet", win_b_o[2], 0);
        drop_piece(2, 4);
        checkOutput("diag_win_b", win_b_o[2], 1);
        checkOutput("diag_win_a", win_a_o[2], 0);
        checkOutput("diag_full", full_o[2], 0);
        checkOutput("diag_turn", turn_o[2], 1);

        // Last piece both wins and fills a 3x3 board
        drop_piece(3, 2); drop_piece(3, 0); drop_piece(3, 1); drop_piece(3, 1);
        drop_piece(3, 0); drop_piece(3, 0); drop_piece(3, 2); drop_piece(3, 1);
        drop_piece(3, 2);
        checkOutput("fillwin_win_a", win_a_o[3], 1);
        checkOutput("fillwin_full", full_o[3], 0);

        // Full 3x2 board with no run of 3
        drop_piece(4, 0); drop_piece(4, 1); drop_piece(4, 2);
        drop_piece(4, 0); drop_piece(4, 1); drop_piece(4, 2);
        checkOutput("draw_full", full_o[4], 1);
        checkOutput("draw_wins", {win_a_o[4], win_b_o[4]}, 0);
        checkOutput("draw_panel", panel4, 12'b10_01_01_10_10_01);

        // Reset during evaluation abandons the move
        reset_all();
        applyStimulus(0, 2);
        checkOutput("midchk_busy", busy_o[0], 1);
        exp_panel    = '0;
        exp_panel[3] = 12'h001;
        checkOutput("midchk_panel", panel0, exp_panel);
        rst = 1'b0;
        #1;
        checkOutput("midchk_cleared", panel0, 0);
        checkOutput("midchk_busy_clr", busy_o[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cur_col = '{3, 3, 3, 1, 1};
        drop_piece(0, 3);
        checkOutput("after_rst_panel", panel0, exp_panel);
        checkOutput("after_rst_turn", turn_o[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
